sdram_init_seq: RTL and testbench
=================================

Name: sdram_init_seq

Overview:
- Power-up sequencer for the SDRAM test system.
- Waits for the system PLL to lock, holds CKE low, then runs the JEDEC SDR SDRAM init sequence on the command bus: 200 us NOP, PRECHARGE ALL, N×AUTO REFRESH, LOAD MODE REGISTER.
- Asserts init_done when complete; after that the main SDRAM controller owns the bus.
- Runs in the 100 MHz system clock domain.

Parameters:
- T_PWR_CYC, 20000: NOP cycles with CKE high before PRECHARGE (200 us at 100 MHz). Must be ≥1.
- T_RP, 2: cycles from PRECHARGE to the next command. Must be ≥1.
- T_RFC, 7: cycles from each AUTO REFRESH to the next command. Must be ≥1.
- T_MRD, 2: cycles from LMR to init_done. Must be ≥1.
- REF_CNT, 8: number of AUTO REFRESH commands. Must be ≥1.
- MODE_REG, 13'h0030: value driven on addr during LMR (CL3, sequential, burst 1).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock, asynchronous to clk.
- cke  out  1  SDRAM clock enable.
- cmd  out  4  {cs_n, ras_n, cas_n, we_n}.
- addr  out  13  SDRAM address.
- ba  out  2  bank address.
- init_done  out  1  high once the sequence has completed.

Behaviour:
- Reset values (rst_n low, applied asynchronously): state=WAIT_LOCK, cke=0, cmd=4'b1111 (INHIBIT), addr=0, ba=0, init_done=0, counters=0, lock sync flops=0.
- Command encodings:
  - INHIBIT 1111
  - NOP 0111
  - PRECHARGE 0010
  - AUTO REFRESH 0001
  - LMR 0000
- pll_locked passes through a 2-flop synchronizer; lock_s is the synchronizer output.
- All outputs are registered. Each command is driven for exactly one cycle; every non-command cycle outside WAIT_LOCK drives NOP.
- State machine:
  - WAIT_LOCK: cke=0, cmd=INHIBIT. Go to PWR_WAIT on the first cycle lock_s=1.
  - PWR_WAIT: cke=1, cmd=NOP, lasts exactly T_PWR_CYC cycles (cycle counter 0..T_PWR_CYC-1), then PRECH.
  - PRECH: one cycle of PRECHARGE, addr[10]=1, other addr bits 0, ba=0. Then PRECH_WAIT.
  - PRECH_WAIT: T_RP-1 NOP cycles (0 cycles if T_RP=1), then REF.
  - REF: one cycle of AUTO REFRESH; refresh counter increments. Then REF_WAIT.
  - REF_WAIT: T_RFC-1 NOP cycles. Then REF if refresh count < REF_CNT, else LMR.
  - LMR: one cycle of LMR, addr=MODE_REG, ba=0. Then LMR_WAIT.
  - LMR_WAIT: T_MRD-1 NOP cycles, then DONE.
  - DONE: terminal. cke=1, cmd=NOP, addr=0, init_done=1, stable until reset.
- Timing relative to the PRECHARGE cycle P:
  - REF k (k=0..REF_CNT-1) at P+T_RP+k·T_RFC.
  - LMR at P+T_RP+REF_CNT·T_RFC.
  - init_done first high at LMR+T_MRD.
  - P is exactly T_PWR_CYC cycles after the first cycle with cke=1.
- Counter widths: wait counter ≥ clog2(max(T_PWR_CYC,T_RFC,T_RP,T_MRD)+1); refresh counter ≥ clog2(REF_CNT+1). No wrap is possible within a state.
- Boundary conditions:
  - Reset asserted mid-sequence returns the block to reset values immediately; the sequence restarts from WAIT_LOCK.
  - lock_s glitching low after WAIT_LOCK is ignored (unless the optional feature is compiled in).
  - pll_locked already high at reset release: the sequence starts after the 2-cycle synchronizer latency.

Optional Feature:
- Macro: SDRAM_INIT_LOCK_WATCH_EN.
- Defined:
  - lock_s=0 in any state other than WAIT_LOCK forces, on the next edge: state=WAIT_LOCK, cke=0, cmd=INHIBIT, init_done=0, counters cleared.
  - Full re-initialisation follows when lock returns.
- Undefined: lock_s is examined only in WAIT_LOCK; DONE is permanent until rst_n.

Test Plan:
- Basic sequence (T_PWR_CYC=10, T_RP=2, T_RFC=3, T_MRD=2, REF_CNT=2); pll_locked rises 5 cycles after reset release:
  - cke rises 3 cycles after pll_locked.
  - PRECHARGE with addr=13'h0400 at P = 10 cycles later.
  - REF at P+2 and P+5; LMR with addr=13'h0030 at P+8.
  - init_done=1 from P+10; NOP on every other cycle.
- Minimum timings (T_RP=T_RFC=T_MRD=1, REF_CNT=1):
  - PRECHARGE at P, REF at P+1, LMR at P+2, init_done at P+3.
  - No NOP gaps between commands.
- PLL never locks: after 1000 cycles, cke=0, cmd=1111, init_done=0.
- Reset pulse while in REF_WAIT during the 2nd refresh:
  - All outputs return to reset values asynchronously.
  - After release, the full sequence repeats with identical offsets.
- Lock drop after DONE, pll_locked low for 4 cycles:
  - Without SDRAM_INIT_LOCK_WATCH_EN, init_done stays 1.
  - With it, init_done=0 and cke=0 three cycles after the drop, and the full sequence reruns after relock.
- Default parameters: exactly 20000 NOP cycles with cke=1 before PRECHARGE; exactly 8 AUTO REFRESH commands, each 7 cycles apart.

Source files
------------

// File: rtl/sdram_init_seq_if.sv
// rtl/sdram_init_seq_if.sv - SDRAM command bus driven by the power-up sequencer
interface sdram_init_seq_if;
  logic        cke;
  logic [3:0]  cmd;
  logic [12:0] addr;
  logic [1:0]  ba;
  logic        init_done;

  modport master (output cke, cmd, addr, ba, init_done);
  modport slave  (input  cke, cmd, addr, ba, init_done);
endinterface

// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - JEDEC SDR SDRAM power-up sequencer (PLL lock, NOP, PRECHARGE ALL, AUTO REFRESH, LMR)
// Optional SDRAM_INIT_LOCK_WATCH_EN: loss of lock outside WAIT_LOCK restarts the whole sequence.
module sdram_init_seq #(
  parameter int          T_PWR_CYC = 20000,
  parameter int          T_RP      = 2,
  parameter int          T_RFC     = 7,
  parameter int          T_MRD     = 2,
  parameter int          REF_CNT   = 8,
  parameter logic [12:0] MODE_REG  = 13'h0030
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  sdram_init_seq_if.master bus
);

  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_PRECH   = 4'b0010;
  localparam logic [3:0] CMD_AREF    = 4'b0001;
  localparam logic [3:0] CMD_LMR     = 4'b0000;

  localparam int M1   = (T_PWR_CYC > T_RFC) ? T_PWR_CYC : T_RFC;
  localparam int M2   = (T_RP > T_MRD) ? T_RP : T_MRD;
  localparam int WMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(WMAX + 1);
  localparam int RW   = $clog2(REF_CNT + 1);

  // Wait states hold T-1 NOPs after the command cycle, so they count 0..T-2.
  localparam logic [CW-1:0] PWR_LAST = CW'(T_PWR_CYC - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'((T_RP > 1) ? T_RP - 2 : 0);
  localparam logic [CW-1:0] RFC_LAST = CW'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CW-1:0] MRD_LAST = CW'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [RW-1:0] REF_TOT  = RW'(REF_CNT);

  typedef enum logic [3:0] {
    WAIT_LOCK,
    PWR_WAIT,
    PRECH,
    PRECH_WAIT,
    REF,
    REF_WAIT,
    LMR,
    LMR_WAIT,
    DONE
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   wait_cnt, wait_d;
  logic [RW-1:0]   ref_cnt, ref_d;
  logic            sync_q, lock_s;
  logic            cke_q, cke_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [12:0]     addr_q, addr_d;
  logic [1:0]      ba_q, ba_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      lock_s   <= 1'b0;
      state    <= WAIT_LOCK;
      wait_cnt <= '0;
      ref_cnt  <= '0;
      cke_q    <= 1'b0;
      cmd_q    <= CMD_INHIBIT;
      addr_q   <= '0;
      ba_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      lock_s   <= sync_q;
      state    <= state_d;
      wait_cnt <= wait_d;
      ref_cnt  <= ref_d;
      cke_q    <= cke_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      ba_q     <= ba_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    wait_d  = wait_cnt;
    ref_d   = ref_cnt;
    cke_d   = 1'b1;
    cmd_d   = CMD_NOP;
    addr_d  = '0;
    ba_d    = '0;
    done_d  = 1'b0;

    case (state)
      WAIT_LOCK: if (lock_s) begin
        state_d = PWR_WAIT;
        wait_d  = '0;
      end
      PWR_WAIT: begin
        if (wait_cnt == PWR_LAST) begin
          wait_d  = '0;
          state_d = PRECH;
        end else begin
          wait_d = wait_cnt + CW'(1);
        end
      end
      PRECH: state_d = (T_RP > 1) ? PRECH_WAIT : REF;
      PRECH_WAIT: begin
        if (wait_cnt == RP_LAST) begin
          wait_d  = '0;
          state_d = REF;
        end else begin
          wait_d = wait_cnt + CW'(1);
        end
      end
      REF: begin
        ref_d = ref_cnt + RW'(1);
        if (T_RFC > 1) state_d = REF_WAIT;
        else           state_d = (ref_d < REF_TOT) ? REF : LMR;
      end
      REF_WAIT: begin
        if (wait_cnt == RFC_LAST) begin
          wait_d  = '0;
          state_d = (ref_cnt < REF_TOT) ? REF : LMR;
        end else begin
          wait_d = wait_cnt + CW'(1);
        end
      end
      LMR: state_d = (T_MRD > 1) ? LMR_WAIT : DONE;
      LMR_WAIT: begin
        if (wait_cnt == MRD_LAST) begin
          wait_d  = '0;
          state_d = DONE;
        end else begin
          wait_d = wait_cnt + CW'(1);
        end
      end
      DONE:    state_d = DONE;
      default: state_d = WAIT_LOCK;
    endcase

`ifdef SDRAM_INIT_LOCK_WATCH_EN
    if (!lock_s && state != WAIT_LOCK) begin
      state_d = WAIT_LOCK;
      wait_d  = '0;
      ref_d   = '0;
    end
`endif

    // Outputs are decoded from the next state so the registered bus lines up with state.
    case (state_d)
      WAIT_LOCK: begin
        cke_d = 1'b0;
        cmd_d = CMD_INHIBIT;
      end
      PRECH: begin
        cmd_d  = CMD_PRECH;
        addr_d = 13'h0400;
      end
      REF:     cmd_d = CMD_AREF;
      LMR: begin
        cmd_d  = CMD_LMR;
        addr_d = MODE_REG;
      end
      DONE:    done_d = 1'b1;
      default: cmd_d = CMD_NOP;
    endcase
  end

  assign bus.cke       = cke_q;
  assign bus.cmd       = cmd_q;
  assign bus.addr      = addr_q;
  assign bus.ba        = ba_q;
  assign bus.init_done = done_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb/tb_sdram_init_seq.sv - scoreboard bench for sdram_init_seq over three parameter sets
module tb_sdram_init_seq;

  localparam int KCKE  = 0;
  localparam int KCMD  = 1;
  localparam int KDONE = 2;

  typedef struct {
    int          kind;
    logic [3:0]  cmd;
    logic [12:0] addr;
    bit          chk_addr;
    int          cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n_v;
  logic       pll_locked;
  int         sel;
  int         cyc = 0;
  int         n_chk;
  int         n_fail;
  ev_t        exp_q[$];
  logic       prev_cke = 1'b0;
  logic       prev_done = 1'b0;

  int p_pwr [3] = '{10, 3, 20000};
  int p_rp  [3] = '{2, 1, 2};
  int p_rfc [3] = '{3, 1, 7};
  int p_mrd [3] = '{2, 1, 2};
  int p_ref [3] = '{2, 1, 8};
  logic [12:0] mode = 13'h0030;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_init_seq_if bus0();
  sdram_init_seq_if bus1();
  sdram_init_seq_if bus2();

  sdram_init_seq #(.T_PWR_CYC(10), .T_RP(2), .T_RFC(3), .T_MRD(2), .REF_CNT(2), .MODE_REG(13'h0030))
    dut0 (.clk(clk), .rst_n(rst_n_v[0]), .pll_locked(pll_locked), .bus(bus0.master));
  sdram_init_seq #(.T_PWR_CYC(3), .T_RP(1), .T_RFC(1), .T_MRD(1), .REF_CNT(1), .MODE_REG(13'h0030))
    dut1 (.clk(clk), .rst_n(rst_n_v[1]), .pll_locked(pll_locked), .bus(bus1.master));
  sdram_init_seq #(.T_PWR_CYC(20000), .T_RP(2), .T_RFC(7), .T_MRD(2), .REF_CNT(8), .MODE_REG(13'h0030))
    dut2 (.clk(clk), .rst_n(rst_n_v[2]), .pll_locked(pll_locked), .bus(bus2.master));

  logic        m_cke, m_done;
  logic [3:0]  m_cmd;
  logic [12:0] m_addr;
  logic [1:0]  m_ba;

  always_comb begin
    case (sel)
      0: begin
        m_cke = bus0.cke; m_cmd = bus0.cmd; m_addr = bus0.addr; m_ba = bus0.ba; m_done = bus0.init_done;
      end
      1: begin
        m_cke = bus1.cke; m_cmd = bus1.cmd; m_addr = bus1.addr; m_ba = bus1.ba; m_done = bus1.init_done;
      end
      default: begin
        m_cke = bus2.cke; m_cmd = bus2.cmd; m_addr = bus2.addr; m_ba = bus2.ba; m_done = bus2.init_done;
      end
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic handle(input int kind);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind=%0d cmd=%b addr=%h cycle %0d with nothing expected",
               kind, m_cmd, m_addr, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cmd != m_cmd || (e.chk_addr && e.addr != m_addr) ||
          m_ba != 2'd0 || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: actual kind=%0d cmd=%b addr=%h ba=%0d cyc=%0d required kind=%0d cmd=%b addr=%h ba=0 cyc=%0d",
                 kind, m_cmd, m_addr, m_ba, cyc, e.kind, e.cmd, e.addr, e.cyc);
      end
    end
  endtask

  // Monitor: bus legality every cycle, events popped from the scoreboard as they appear.
  always @(negedge clk) begin
    if (!m_cke) begin
      chk("cke_low_bus", int'({m_cmd, m_done}), int'({4'b1111, 1'b0}));
    end else if (!(m_cmd inside {4'b0010, 4'b0001, 4'b0000})) begin
      chk("nop_fill", int'(m_cmd), int'(4'b0111));
    end
    if (m_done) chk("done_addr", int'(m_addr), 0);
    if (m_cke && !prev_cke) handle(KCKE);
    if (m_cke && (m_cmd inside {4'b0010, 4'b0001, 4'b0000})) handle(KCMD);
    if (m_done && !prev_done) handle(KDONE);
    prev_cke  = m_cke;
    prev_done = m_done;
  end

  task automatic push_ev(input int kind, input logic [3:0] c, input logic [12:0] a,
                         input bit ca, input int t);
    ev_t e;
    e.kind = kind; e.cmd = c; e.addr = a; e.chk_addr = ca; e.cyc = t;
    exp_q.push_back(e);
  endtask

  // Reference schedule: lock seen at cycle l, cke three cycles later, then fixed offsets from PRECHARGE.
  task automatic push_seq(input int l);
    int p, lmr;
    p   = l + 3 + p_pwr[sel];
    lmr = p + p_rp[sel] + p_ref[sel] * p_rfc[sel];
    push_ev(KCKE, 4'b0111, 13'h0, 1'b1, l + 3);
    push_ev(KCMD, 4'b0010, 13'h0400, 1'b1, p);
    for (int k = 0; k < p_ref[sel]; k++)
      push_ev(KCMD, 4'b0001, 13'h0, 1'b0, p + p_rp[sel] + k * p_rfc[sel]);
    push_ev(KCMD, 4'b0000, mode, 1'b1, lmr);
    push_ev(KDONE, 4'b0111, 13'h0, 1'b1, lmr + p_mrd[sel]);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n_v = 3'b000;
    #1;
    chk("rst_cke", int'(m_cke), 0);
    chk("rst_cmd", int'(m_cmd), int'(4'b1111));
    chk("rst_addr", int'(m_addr), 0);
    chk("rst_ba", int'(m_ba), 0);
    chk("rst_done", int'(m_done), 0);
    exp_q.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
    tick(6);
  endtask

  int l, r, p;

  initial begin
    rst_n_v = 3'b000; pll_locked = 1'b0; sel = 0; n_chk = 0; n_fail = 0;
    tick(3);
    reset_all();

    // Basic sequence, lock five cycles after release
    tick(2); rst_n_v[0] = 1'b1;
    tick(5); pll_locked = 1'b1; l = cyc; push_seq(l);
    drain("basic_drain", 200);
    chk("basic_done", int'(m_done), 1);

    // Lock drop after DONE for four cycles
    pll_locked = 1'b0;
    tick(3);
`ifdef SDRAM_INIT_LOCK_WATCH_EN
    chk("drop_done", int'(m_done), 0);
    chk("drop_cke", int'(m_cke), 0);
    tick(1); pll_locked = 1'b1; push_seq(cyc);
    drain("relock_drain", 200);
`else
    chk("drop_done", int'(m_done), 1);
    chk("drop_cke", int'(m_cke), 1);
    tick(1); pll_locked = 1'b1;
    tick(20);
    chk("drop_done_hold", int'(m_done), 1);
`endif

    // Reset pulse in REF_WAIT after the second refresh; lock already high at release
    reset_all();
    tick(2); rst_n_v[0] = 1'b1; r = cyc; push_seq(r);
    p = r + 3 + p_pwr[0];
    tick(p + p_rp[0] + p_rfc[0] + 1 - cyc);
    chk("pre_reset_pending", exp_q.size(), 2);
    reset_all();
    tick(2); rst_n_v[0] = 1'b1; r = cyc; push_seq(r);
    drain("restart_drain", 200);

    // Randomised lock arrival
    for (int i = 0; i < 4; i++) begin
      reset_all();
      pll_locked = 1'b0;
      tick(2); rst_n_v[0] = 1'b1;
      tick(1 + $urandom_range(0, 15)); pll_locked = 1'b1; push_seq(cyc);
      drain("rand_drain", 200);
    end

    // PLL never locks
    reset_all();
    pll_locked = 1'b0;
    tick(2); rst_n_v[0] = 1'b1;
    tick(1000);
    chk("nolock_cke", int'(m_cke), 0);
    chk("nolock_cmd", int'(m_cmd), int'(4'b1111));
    chk("nolock_done", int'(m_done), 0);

    // Minimum timings
    reset_all();
    sel = 1;
    tick(2); rst_n_v[1] = 1'b1;
    tick(1 + $urandom_range(0, 10)); pll_locked = 1'b1; push_seq(cyc);
    drain("min_drain", 100);

    // Default parameters
    reset_all();
    pll_locked = 1'b0;
    sel = 2;
    tick(2); rst_n_v[2] = 1'b1;
    tick(1 + $urandom_range(0, 5)); pll_locked = 1'b1; push_seq(cyc);
    drain("default_drain", 21000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
